i_cache_nway: RTL
=================

Name: i_cache_nway

Overview:
- Parametrised N-way set-associative instruction cache; next generation of the 2-way direct-fetch icache.
- Sits between the IF stage and the AXI4 arbiter read port.
- Adds configurable ways, sets and line size, multi-beat burst refill, true LRU, response back-pressure and fence.i invalidation.
- One request in flight; blocking on miss.

Parameters:
ADDR_W, 64, fetch/memory address width
INST_W, 32, instruction width returned to IF
WAYS, 2, associativity (power of 2, >=2)
SETS, 64, sets per way (power of 2)
LINE_BYTES, 16, line size (8/16/32/64); refill beats BEATS = LINE_BYTES/8 of 64 bits

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
inst_ena  in  1  IF request valid
inst_addr  in  ADDR_W  fetch address; bits[1:0] ignored
inst_ready  out  1  cache accepts request (IDLE only)
inst_valid  out  1  instruction valid
inst_data  out  INST_W  instruction
inst_resp_ready  in  1  IF accepts response
fence_i  in  1  invalidate-all request (pulse)
fence_done  out  1  one-cycle pulse, invalidation complete
cache_read_ena  out  1  burst read request to arbiter
cache_addr  out  ADDR_W  line-aligned refill address
cache_in_data  in  64  refill beat data
cache_in_valid  in  1  refill beat valid
cache_in_last  in  1  final beat of burst
cache_read_resp  out  1  beat accepted (equals cache_in_valid in REFILL)

Behaviour:
- Address split: OFF = log2(LINE_BYTES), IDX = log2(SETS), TAG_W = ADDR_W-IDX-OFF. Word select = addr[OFF-1:2].
- Reset (rst=0, async) drives:
  - state to IDLE; all valid bits 0; LRU ages per set: way w = w.
  - outputs 0, except inst_ready = 1 after release.
- Request handshake: inst_ena && inst_ready latches the address and moves IDLE->LOOKUP.
- States (one-hot): IDLE, LOOKUP, HIT, MISS_REQ, REFILL, FLUSH.
- LOOKUP:
  - All ways compared against the latched tag in the cycle after acceptance.
  - Hit -> HIT, with inst_valid=1 in that same cycle (1-cycle hit latency). Miss -> MISS_REQ.
  - More than one way matching is impossible; the bench asserts this never occurs.
- HIT:
  - inst_valid and inst_data held stable until inst_resp_ready.
  - LRU updated on the handshake cycle: the hit way takes age 0; ways younger than its old age increment.
  - Then -> IDLE, or FLUSH if a fence is pending.
- MISS_REQ:
  - cache_read_ena=1; cache_addr = {tag, idx, OFF zeros}.
  - Leaves on the first cache_in_valid, which is also accepted as beat 0 (-> REFILL).
- Victim selection: lowest-index invalid way; else the way with age WAYS-1. Fixed at MISS_REQ entry.
- REFILL:
  - Beat counter 0..BEATS-1; each valid beat is written to victim data[idx][beat]. Gaps in cache_in_valid are tolerated.
  - On cache_in_last (or counter = BEATS-1): write tag, set valid, -> LOOKUP (replay, which hits).
  - cache_in_last arriving before BEATS beats: remaining words are undefined and the line is still marked valid. This is a protocol error and is flagged in simulation.
- fence_i:
  - In IDLE: -> FLUSH next cycle.
  - Otherwise latched as pending and serviced after the current response handshake.
  - FLUSH (1 cycle): all valid bits cleared, ages reset, fence_done pulse, -> IDLE.
  - fence_i together with inst_ena in IDLE: the fence wins and inst_ready=0 that cycle.
- Reset during REFILL: the partial line is discarded (valid stays 0). The arbiter shares rst, so the burst is abandoned on both sides.
- Beat counter and ages wrap-free: saturation is impossible by construction.

Decomposition:
- Shared header (alongside the existing defines): state encodings; ABLE/ENABLE levels; derived widths OFF, IDX, TAG_W, BEATS, AGE_W = log2(WAYS).
- Sub-module i_cache_way_array, instantiated WAYS times via generate:
  - tag, valid and data storage for one way;
  - combinational read by idx;
  - synchronous beat write and tag write;
  - global valid clear.
- LRU ages and the FSM stay in the top.

Test Plan (WAYS=2, SETS=64, LINE_BYTES=16):
- Cold miss at 0x8000_0000 with beats 0x1111_2222_3333_4444, 0x5555_6666_7777_8888:
  - cache_read_ena=1 and cache_addr=0x8000_0000, then inst_data=0x3333_4444.
  - 0x8000_000C then returns 0x5555_6666 one cycle after acceptance, with no cache_read_ena.
- Set conflict: fill 0x8000_0000, then 0x8000_0400, re-hit 0x8000_0000, then miss 0x8000_0800 -> the 0x8000_0400 line is evicted; 0x8000_0000 still hits.
- fence_i pulse in IDLE -> fence_done exactly one cycle later; the next access to 0x8000_0000 misses.
- inst_resp_ready held 0 for 5 cycles on a hit:
  - inst_valid and inst_data stable throughout;
  - inst_ready=0;
  - LRU unchanged until the handshake.
- Refill with 3-cycle gaps between beats: data is correct, and cache_read_resp pulses only on the valid cycles.
- rst asserted low after refill beat 0 -> all outputs 0 immediately; after release, 0x8000_0000 misses again.

Source files
------------

// File: rtl/i_cache_nway_pkg.sv
// ============================================================================
// Module      : i_cache_nway_pkg
// Description : Shared state encodings, enable levels and width helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i_cache_nway_pkg;

    localparam logic c_ENABLE  = 1'b1;
    localparam logic c_DISABLE = 1'b0;
    localparam int   c_BEAT_W  = 64;

    typedef enum logic [5:0] {
        S_IDLE     = 6'b000001,
        S_LOOKUP   = 6'b000010,
        S_HIT      = 6'b000100,
        S_MISS_REQ = 6'b001000,
        S_REFILL   = 6'b010000,
        S_FLUSH    = 6'b100000
    } state_t;

    // Index width that stays legal when only one element exists.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/i_cache_way_array.sv
// ============================================================================
// Module      : i_cache_way_array
// Description : Tag, valid and line storage for one cache way.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i_cache_way_array
    import i_cache_nway_pkg::*;
#(
    parameter int SETS   = 64,
    parameter int IDX_W  = 6,
    parameter int TAG_W  = 54,
    parameter int BEATS  = 2,
    parameter int BEAT_W = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_clr,
    input  logic [IDX_W-1:0]           i_idx,
    input  logic                       i_beat_we,
    input  logic [BEAT_W-1:0]          i_beat,
    input  logic [c_BEAT_W-1:0]        i_beat_data,
    input  logic                       i_tag_we,
    input  logic [TAG_W-1:0]           i_tag,
    output logic                       o_valid,
    output logic [TAG_W-1:0]           o_tag,
    output logic [BEATS*c_BEAT_W-1:0]  o_line
);

    logic [SETS-1:0]     r_valid;
    logic [TAG_W-1:0]    r_tag  [SETS];
    logic [c_BEAT_W-1:0] r_data [SETS][BEATS];

    // Only valid bits need reset; tag and data are qualified by them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (i_clr) begin
            r_valid <= '0;
        end else if (i_tag_we) begin
            r_valid[i_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_tag_we) begin
            r_tag[i_idx] <= i_tag;
        end
        if (i_beat_we) begin
            r_data[i_idx][i_beat] <= i_beat_data;
        end
    end

    assign o_valid = r_valid[i_idx];
    assign o_tag   = r_tag[i_idx];

    generate
        for (genvar gb = 0; gb < BEATS; gb++) begin : g_line
            assign o_line[gb*c_BEAT_W +: c_BEAT_W] = r_data[i_idx][gb];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/i_cache_nway.sv
// ============================================================================
// Module      : i_cache_nway
// Description : N-way set-associative blocking icache with burst refill,
//               true LRU, response back-pressure and fence.i invalidation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i_cache_nway
    import i_cache_nway_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int INST_W     = 32,
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_BYTES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_ena,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_ready,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_data,
    input  logic              inst_resp_ready,
    input  logic              fence_i,
    output logic              fence_done,
    output logic              cache_read_ena,
    output logic [ADDR_W-1:0] cache_addr,
    input  logic [63:0]       cache_in_data,
    input  logic              cache_in_valid,
    input  logic              cache_in_last,
    output logic              cache_read_resp
);

    localparam int OFF    = $clog2(LINE_BYTES);
    localparam int IDX    = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX - OFF;
    localparam int BEATS  = LINE_BYTES / 8;
    localparam int AGE_W  = $clog2(WAYS);
    localparam int BEAT_W = clog2_min1(BEATS);
    localparam int LINE_W = BEATS * c_BEAT_W;

    state_t             r_state, w_state_nxt;
    logic [TAG_W-1:0]   r_tag;
    logic [IDX-1:0]     r_idx;
    logic [OFF-3:0]     r_wsel;
    logic               r_fence_pend;
    logic [AGE_W-1:0]   r_victim;
    logic [AGE_W-1:0]   r_hit_way;
    logic [BEAT_W-1:0]  r_beat;
    logic [AGE_W-1:0]   r_age [SETS][WAYS];

    logic [WAYS-1:0]    w_way_valid;
    logic [TAG_W-1:0]   w_way_tag  [WAYS];
    logic [LINE_W-1:0]  w_way_line [WAYS];
    logic [WAYS-1:0]    w_hit_vec;
    logic               w_hit;
    logic [AGE_W-1:0]   w_hit_way;
    logic [AGE_W-1:0]   w_victim;
    logic [AGE_W-1:0]   w_sel_way;
    logic [AGE_W-1:0]   w_hit_age;
    logic [LINE_W-1:0]  w_sel_line;
    logic               w_req_acc;
    logic               w_hit_hs;
    logic               w_beat_acc;
    logic               w_line_done;
    logic               w_fence_any;
    logic               w_unused;

    assign w_unused = &{1'b0, inst_addr[1:0]};

    generate
        for (genvar gw = 0; gw < WAYS; gw++) begin : g_way
            i_cache_way_array #(
                .SETS   (SETS),
                .IDX_W  (IDX),
                .TAG_W  (TAG_W),
                .BEATS  (BEATS),
                .BEAT_W (BEAT_W)
            ) u_way (
                .clk         (clk),
                .rst_n       (rst),
                .i_clr       (r_state == S_FLUSH),
                .i_idx       (r_idx),
                .i_beat_we   (w_beat_acc && (r_victim == AGE_W'(gw))),
                .i_beat      (r_beat),
                .i_beat_data (cache_in_data),
                .i_tag_we    (w_line_done && (r_victim == AGE_W'(gw))),
                .i_tag       (r_tag),
                .o_valid     (w_way_valid[gw]),
                .o_tag       (w_way_tag[gw]),
                .o_line      (w_way_line[gw])
            );
            assign w_hit_vec[gw] = w_way_valid[gw] && (w_way_tag[gw] == r_tag);
        end
    endgenerate

    // Victim: oldest way, overridden by the lowest-index invalid way.
    always_comb begin
        w_hit_way = '0;
        w_victim  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (w_hit_vec[w]) begin
                w_hit_way = AGE_W'(w);
            end
            if (r_age[r_idx][w] == AGE_W'(WAYS - 1)) begin
                w_victim = AGE_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!w_way_valid[w]) begin
                w_victim = AGE_W'(w);
            end
        end
    end

    assign w_hit       = |w_hit_vec;
    assign w_sel_way   = (r_state == S_LOOKUP) ? w_hit_way : r_hit_way;
    assign w_hit_age   = r_age[r_idx][w_sel_way];
    assign w_sel_line  = w_way_line[w_sel_way];
    assign w_req_acc   = inst_ena && inst_ready;
    assign w_hit_hs    = inst_valid && inst_resp_ready;
    assign w_beat_acc  = cache_in_valid && ((r_state == S_MISS_REQ) || (r_state == S_REFILL));
    assign w_line_done = w_beat_acc && (cache_in_last || (r_beat == BEAT_W'(BEATS - 1)));
    assign w_fence_any = r_fence_pend || fence_i;

    always_comb begin
        w_state_nxt     = r_state;
        inst_ready      = c_DISABLE;
        inst_valid      = c_DISABLE;
        inst_data       = '0;
        fence_done      = c_DISABLE;
        cache_read_ena  = c_DISABLE;
        cache_addr      = '0;
        cache_read_resp = c_DISABLE;
        case (r_state)
            S_IDLE: begin
                inst_ready = rst && !fence_i;
                if (fence_i) begin
                    w_state_nxt = S_FLUSH;
                end else if (inst_ena) begin
                    w_state_nxt = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (w_hit) begin
                    inst_valid = c_ENABLE;
                    inst_data  = w_sel_line[r_wsel*INST_W +: INST_W];
                    if (inst_resp_ready) begin
                        w_state_nxt = w_fence_any ? S_FLUSH : S_IDLE;
                    end else begin
                        w_state_nxt = S_HIT;
                    end
                end else begin
                    w_state_nxt = S_MISS_REQ;
                end
            end
            S_HIT: begin
                inst_valid = c_ENABLE;
                inst_data  = w_sel_line[r_wsel*INST_W +: INST_W];
                if (inst_resp_ready) begin
                    w_state_nxt = w_fence_any ? S_FLUSH : S_IDLE;
                end
            end
            S_MISS_REQ: begin
                cache_read_ena  = c_ENABLE;
                cache_addr      = {r_tag, r_idx, {OFF{1'b0}}};
                cache_read_resp = cache_in_valid;
                if (w_beat_acc) begin
                    w_state_nxt = w_line_done ? S_LOOKUP : S_REFILL;
                end
            end
            S_REFILL: begin
                cache_read_resp = cache_in_valid;
                if (w_line_done) begin
                    w_state_nxt = S_LOOKUP;
                end
            end
            S_FLUSH: begin
                fence_done  = c_ENABLE;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_tag        <= '0;
            r_idx        <= '0;
            r_wsel       <= '0;
            r_fence_pend <= 1'b0;
            r_victim     <= '0;
            r_hit_way    <= '0;
            r_beat       <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_age[s][w] <= AGE_W'(w);
                end
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_req_acc) begin
                {r_tag, r_idx, r_wsel} <= inst_addr[ADDR_W-1:2];
            end
            if (r_state == S_LOOKUP) begin
                r_hit_way <= w_hit_way;
                r_victim  <= w_victim;
                r_beat    <= '0;
            end
            if (w_beat_acc) begin
                r_beat <= r_beat + BEAT_W'(1);
            end
            if (r_state == S_FLUSH) begin
                r_fence_pend <= 1'b0;
            end else if (fence_i && (r_state != S_IDLE)) begin
                r_fence_pend <= 1'b1;
            end
            // Hit way becomes youngest; only ways younger than it age by one.
            if (r_state == S_FLUSH) begin
                for (int s = 0; s < SETS; s++) begin
                    for (int w = 0; w < WAYS; w++) begin
                        r_age[s][w] <= AGE_W'(w);
                    end
                end
            end else if (w_hit_hs) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (AGE_W'(w) == w_sel_way) begin
                        r_age[r_idx][w] <= '0;
                    end else if (r_age[r_idx][w] < w_hit_age) begin
                        r_age[r_idx][w] <= r_age[r_idx][w] + AGE_W'(1);
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire
